// File: rtl/freq_gen.sv
// Programmable 50%-duty square-wave generator built on a modulo-CLK_HZ phase accumulator.
// Optional macro FREQ_GEN_BURST_EN adds burst_len/burst_done for counted bursts of rising edges.
module freq_gen #(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned FW     = 14,
  parameter int unsigned ACC_W  = 28
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [FW-1:0] freq_in,
  input  logic          freq_valid,
  output logic          freq_ready,
  output logic          sig_out,
  output logic          active,
  output logic [FW-1:0] freq_cur
`ifdef FREQ_GEN_BURST_EN
  ,
  input  logic [15:0]   burst_len,
  output logic          burst_done
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [ACC_W-1:0] CLK_W = ACC_W'(CLK_HZ);

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              sig_q, sig_d;
  logic [FW-1:0]     cur_q, cur_d;
  logic [FW-1:0]     pend_q, pend_d;
  logic              pend_vld_q, pend_vld_d;
  logic              ready_q, ready_d;

  logic [ACC_W-1:0]  sum, acc_next;
  logic              toggle, fall, xfer, apply_req;
  logic [FW-1:0]     apply_val;

`ifdef FREQ_GEN_BURST_EN
  logic [15:0]       blen_q, blen_d;
  logic [15:0]       rcnt_q, rcnt_d;
  logic              bdrain_q, bdrain_d;
  logic              bdone_q, bdone_d;
  logic              block_q, block_d;
  logic              rise;
`endif

  always_comb begin
    sum        = acc_q + ACC_W'({cur_q, 1'b0});
    toggle     = (sum >= CLK_W);
    acc_next   = toggle ? (sum - CLK_W) : sum;
    fall       = toggle & sig_q;
    xfer       = freq_valid & ready_q;
    // Only one of these can be true: a held pending value keeps ready low.
    apply_req  = pend_vld_q | xfer;
    apply_val  = pend_vld_q ? pend_q : freq_in;

    state_d    = state_q;
    acc_d      = acc_q;
    sig_d      = sig_q;
    cur_d      = cur_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    ready_d    = ~pend_vld_q;
`ifdef FREQ_GEN_BURST_EN
    rise       = toggle & ~sig_q;
    blen_d     = blen_q;
    rcnt_d     = rcnt_q;
    bdrain_d   = bdrain_q;
    bdone_d    = 1'b0;
    block_d    = block_q & en;
`endif

    case (state_q)
      IDLE: begin
        if (xfer) cur_d = freq_in;
`ifdef FREQ_GEN_BURST_EN
        if (en && (cur_q != '0) && !block_q) begin
          blen_d   = burst_len;
          rcnt_d   = '0;
          bdrain_d = 1'b0;
`else
        if (en && (cur_q != '0)) begin
`endif
          state_d = RUN;
          acc_d   = '0;
          sig_d   = 1'b0;
        end
      end
      default: begin
        if (xfer) begin
          pend_d     = freq_in;
          pend_vld_d = 1'b1;
          ready_d    = 1'b0;
        end
        if ((state_q == RUN) && !en && !sig_q) begin
          // Low phase: stop at once; an outstanding update has no edge to wait for.
          state_d = IDLE;
          if (apply_req) begin
            cur_d      = apply_val;
            pend_vld_d = 1'b0;
          end
        end else begin
          acc_d = acc_next;
          sig_d = sig_q ^ toggle;
          if ((state_q == RUN) && !en) state_d = DRAIN;
`ifdef FREQ_GEN_BURST_EN
          if ((state_q == RUN) && rise) begin
            rcnt_d = rcnt_q + 16'd1;
            if ((blen_q != '0) && ((rcnt_q + 16'd1) == blen_q)) begin
              state_d  = DRAIN;
              bdrain_d = 1'b1;
            end
          end
`endif
          if (fall) begin
            if (apply_req) begin
              cur_d      = apply_val;
              pend_vld_d = 1'b0;
              acc_d      = '0;
              if (apply_val == '0) state_d = IDLE;
            end
            if ((state_q == DRAIN) || !en) state_d = IDLE;
          end
        end
      end
    endcase

`ifdef FREQ_GEN_BURST_EN
    if ((state_q != IDLE) && (state_d == IDLE) && bdrain_q) begin
      bdone_d = 1'b1;
      block_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      sig_q      <= 1'b0;
      cur_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      ready_q    <= 1'b1;
`ifdef FREQ_GEN_BURST_EN
      blen_q     <= '0;
      rcnt_q     <= '0;
      bdrain_q   <= 1'b0;
      bdone_q    <= 1'b0;
      block_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      sig_q      <= sig_d;
      cur_q      <= cur_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      ready_q    <= ready_d;
`ifdef FREQ_GEN_BURST_EN
      blen_q     <= blen_d;
      rcnt_q     <= rcnt_d;
      bdrain_q   <= bdrain_d;
      bdone_q    <= bdone_d;
      block_q    <= block_d;
`endif
    end
  end

  assign sig_out    = sig_q;
  assign freq_ready = ready_q;
  assign freq_cur   = cur_q;
  assign active     = (state_q != IDLE);
`ifdef FREQ_GEN_BURST_EN
  assign burst_done = bdone_q;
`endif

endmodule

// File: tb/tb_freq_gen.sv
// Self-checking bench for freq_gen at CLK_HZ=1000: vector table for reset/IDLE handshake,
// scoreboard of expected sig_out edge cycles derived from ceil(m*CLK_HZ/(2*F)).
module tb_freq_gen;

  localparam int CLK = 1000;
  localparam int FW  = 8;

  logic          clk = 1'b0;
  logic          rst_n, en, freq_valid;
  logic [FW-1:0] freq_in;
  logic          freq_ready, sig_out, active;
  logic [FW-1:0] freq_cur;
`ifdef FREQ_GEN_BURST_EN
  logic [15:0]   burst_len;
  logic          burst_done;
`endif

  freq_gen #(.CLK_HZ(CLK), .FW(FW), .ACC_W(11)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .freq_in(freq_in), .freq_valid(freq_valid),
    .freq_ready(freq_ready), .sig_out(sig_out), .active(active), .freq_cur(freq_cur)
`ifdef FREQ_GEN_BURST_EN
    , .burst_len(burst_len), .burst_done(burst_done)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { int c; logic lvl; } ev_t;
  ev_t sb[$];
  int  rise_cnt = 0;
  logic prev_sig = 1'b0;

  // Toggle m after phase start lands ceil(m*CLK/(2F)) cycles later; odd m are rises.
  task automatic push_toggles(input int base, input int f, input int m_from, input int m_to);
    ev_t ev;
    for (int m = m_from; m <= m_to; m++) begin
      ev.c   = base + (m * CLK + 2 * f - 1) / (2 * f);
      ev.lvl = (m % 2 == 1);
      sb.push_back(ev);
    end
  endtask

  always @(negedge clk) begin
    ev_t ev;
    if (rst_n && (sig_out !== prev_sig)) begin
      if (sig_out === 1'b1) rise_cnt++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_edge: level %0d at cycle %0d, required no edge", sig_out, cyc);
      end else begin
        ev = sb.pop_front();
        chk("edge_cycle", cyc, ev.c);
        chk("edge_level", {31'd0, sig_out}, {31'd0, ev.lvl});
      end
    end
    prev_sig = sig_out;
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic load_freq(input logic [FW-1:0] f);
    freq_valid = 1'b1;
    freq_in    = f;
    @(negedge clk);
    freq_valid = 1'b0;
    chk("idle_load_cur", freq_cur, f);
  endtask

  typedef struct {
    logic          rst_n, en, valid;
    logic [FW-1:0] fin;
    logic          exp_ready, exp_active, exp_sig;
    logic [FW-1:0] exp_cur;
  } vec_t;
  vec_t vec [9];

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1);
  end

  initial begin
    int e, r0;
    vec[0] = '{1'b0, 1'b1, 1'b1, 8'd50,  1'b1, 1'b0, 1'b0, 8'd0};
    vec[1] = '{1'b0, 1'b1, 1'b1, 8'd50,  1'b1, 1'b0, 1'b0, 8'd0};
    vec[2] = '{1'b0, 1'b1, 1'b1, 8'd50,  1'b1, 1'b0, 1'b0, 8'd0};
    vec[3] = '{1'b1, 1'b1, 1'b1, 8'd50,  1'b1, 1'b0, 1'b0, 8'd50};
    vec[4] = '{1'b1, 1'b0, 1'b1, 8'd100, 1'b1, 1'b0, 1'b0, 8'd100};
    vec[5] = '{1'b1, 1'b0, 1'b0, 8'd7,   1'b1, 1'b0, 1'b0, 8'd100};
    vec[6] = '{1'b1, 1'b0, 1'b1, 8'd0,   1'b1, 1'b0, 1'b0, 8'd0};
    vec[7] = '{1'b1, 1'b1, 1'b0, 8'd0,   1'b1, 1'b0, 1'b0, 8'd0};
    vec[8] = '{1'b1, 1'b0, 1'b1, 8'd100, 1'b1, 1'b0, 1'b0, 8'd100};

    rst_n = 1'b0; en = 1'b0; freq_valid = 1'b0; freq_in = '0;
`ifdef FREQ_GEN_BURST_EN
    burst_len = '0;
`endif
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      rst_n = vec[i].rst_n; en = vec[i].en; freq_valid = vec[i].valid; freq_in = vec[i].fin;
      @(negedge clk);
      chk($sformatf("vec%0d_ready", i),  {31'd0, freq_ready}, {31'd0, vec[i].exp_ready});
      chk($sformatf("vec%0d_active", i), {31'd0, active},     {31'd0, vec[i].exp_active});
      chk($sformatf("vec%0d_sig", i),    {31'd0, sig_out},    {31'd0, vec[i].exp_sig});
      chk($sformatf("vec%0d_cur", i),    freq_cur,            vec[i].exp_cur);
    end
    en = 1'b0; freq_valid = 1'b0;

    // 100 Hz run, then en dropped one cycle after a rise: high phase completes.
    e = cyc + 1; en = 1'b1;
    push_toggles(e, 100, 1, 8);
    wait_cyc(e);      chk("run_active", active, 1); chk("run_cur", freq_cur, 100);
    wait_cyc(e + 35); en = 1'b0;
    wait_cyc(e + 39); chk("drain_active_high", active, 1); chk("drain_sig_high", sig_out, 1);
    wait_cyc(e + 40); chk("drain_active_fall", active, 0);
    wait_cyc(e + 60); chk("drain_sb_empty", sb.size(), 0);

    // en dropped during the low phase: straight to IDLE.
    e = cyc + 1; en = 1'b1;
    push_toggles(e, 100, 1, 2);
    wait_cyc(e + 11); en = 1'b0; chk("low_stop_active_before", active, 1);
    wait_cyc(e + 12); chk("low_stop_active_after", active, 0);
    wait_cyc(e + 30); chk("low_stop_sb_empty", sb.size(), 0);

    // 3 Hz: 3 rises per 1000-cycle window, 9 in 3000 cycles.
    load_freq(8'd3);
    e = cyc + 1; en = 1'b1; r0 = rise_cnt;
    push_toggles(e, 3, 1, 18);
    wait_cyc(e + 1000); chk("f3_win1", rise_cnt - r0, 3);
    wait_cyc(e + 2000); chk("f3_win2", rise_cnt - r0, 6);
    wait_cyc(e + 3000); chk("f3_win3", rise_cnt - r0, 9); en = 1'b0;
    wait_cyc(e + 3001); chk("f3_idle", active, 0);
    wait_cyc(e + 3010); chk("f3_sb_empty", sb.size(), 0);

    // Switch 100 -> 250 while high: applied at the falling toggle.
    load_freq(8'd100);
    e = cyc + 1; en = 1'b1;
    push_toggles(e, 100, 1, 2);
    push_toggles(e + 10, 250, 1, 4);
    wait_cyc(e + 6);  freq_valid = 1'b1; freq_in = 8'd250;
    wait_cyc(e + 7);  freq_valid = 1'b0;
    chk("sw_ready_low", freq_ready, 0); chk("sw_cur_old", freq_cur, 100);
    wait_cyc(e + 9);  chk("sw_ready_hold", freq_ready, 0); chk("sw_cur_hold", freq_cur, 100);
    wait_cyc(e + 10); chk("sw_cur_new", freq_cur, 250); chk("sw_ready_lag", freq_ready, 0);
    wait_cyc(e + 11); chk("sw_ready_back", freq_ready, 1);
    wait_cyc(e + 18); en = 1'b0;
    wait_cyc(e + 19); chk("sw_idle", active, 0);
    wait_cyc(e + 30); chk("sw_sb_empty", sb.size(), 0);

`ifdef FREQ_GEN_BURST_EN
    // Burst of 3 with en held high; no restart until en toggles.
    load_freq(8'd100);
    burst_len = 16'd3;
    e = cyc + 1; en = 1'b1; r0 = rise_cnt;
    push_toggles(e, 100, 1, 6);
    wait_cyc(e + 29); chk("burst_done_pre", burst_done, 0);
    wait_cyc(e + 30); chk("burst_done_pulse", burst_done, 1); chk("burst_idle", active, 0);
    wait_cyc(e + 31); chk("burst_done_post", burst_done, 0);
    wait_cyc(e + 60); chk("burst_rises", rise_cnt - r0, 3); chk("burst_no_restart", active, 0);
    chk("burst_sb_empty", sb.size(), 0);
    en = 1'b0; burst_len = '0;
    wait_cyc(e + 61); en = 1'b1;
    wait_cyc(e + 62); chk("burst_reentry", active, 1); en = 1'b0;
    wait_cyc(e + 63); chk("burst_reentry_stop", active, 0); chk("burst_no_done", burst_done, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
